// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL power-down, filters the lock signal,
// holds the fabric reset until lock is stable, and retries or fails on timeout.
module pll_lock_supervisor #(
    parameter int PD_CYCLES    = 64,
    parameter int LOCK_FILTER  = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int RST_HOLD     = 32,
    parameter int RETRY_MAX    = 3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_powerdown_n,
    output logic       fabric_reset,
    output logic       locked,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);
    localparam int PD_W   = $clog2(PD_CYCLES) + 1;
    localparam int FILT_W = $clog2(LOCK_FILTER) + 1;
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT) + 1;
    localparam int HOLD_W = $clog2(RST_HOLD) + 1;

    localparam logic [PD_W-1:0]   PD_LAST   = PD_W'(PD_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [3:0]        RETRY_LIM = 4'(RETRY_MAX);

    typedef enum logic [2:0] {
        ST_POWERDOWN,
        ST_WAIT_LOCK,
        ST_HOLD,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t state, state_nxt;

    logic lock_meta, lock_s;

    logic [PD_W-1:0]   pd_cnt,   pd_nxt;
    logic [FILT_W-1:0] filt_cnt, filt_nxt;
    logic [TMO_W-1:0]  tmo_cnt,  tmo_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [3:0]        retry_nxt, retry_inc;
    logic [7:0]        loss_nxt;

    // Two-flop synchronizer bringing the asynchronous PLL lock into the supervisor clock
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Next-state, counter and status computation; counters not explicitly kept fall to zero,
    // which is what clears them on every state change and on a relock request
    always_comb begin
        state_nxt = state;
        pd_nxt    = '0;
        filt_nxt  = '0;
        tmo_nxt   = '0;
        hold_nxt  = '0;
        retry_nxt = retry_cnt;
        loss_nxt  = lock_loss_cnt;
        retry_inc = retry_cnt + 4'd1;

        if (relock_req) begin
            // Highest priority: restart the power-cycle from scratch, any lock loss is ignored
            state_nxt = ST_POWERDOWN;
            retry_nxt = '0;
        end else begin
            case (state)
                ST_POWERDOWN: begin
                    if (pd_cnt == PD_LAST) state_nxt = ST_WAIT_LOCK;
                    else                   pd_nxt    = pd_cnt + 1'b1;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s && (filt_cnt == FILT_LAST)) begin
                        // Filter completion beats a coincident timeout
                        state_nxt = ST_HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        retry_nxt = retry_inc;
                        state_nxt = (retry_inc == RETRY_LIM) ? ST_FAIL : ST_POWERDOWN;
                    end else begin
                        filt_nxt = lock_s ? filt_cnt + 1'b1 : '0;
                        tmo_nxt  = tmo_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!lock_s) begin
                        // Lock dropped before release: retry the filter, not a counted loss
                        state_nxt = ST_WAIT_LOCK;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_nxt = ST_RUN;
                        retry_nxt = '0;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_nxt = ST_POWERDOWN;
                        if (lock_loss_cnt != 8'hFF) loss_nxt = lock_loss_cnt + 8'd1;
                    end
                end
                ST_FAIL: begin
                    state_nxt = ST_FAIL;
                end
                default: begin
                    state_nxt = ST_POWERDOWN;
                end
            endcase
        end
    end

    // State, counters and registered outputs decoded from the next state
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state           <= ST_POWERDOWN;
            pd_cnt          <= '0;
            filt_cnt        <= '0;
            tmo_cnt         <= '0;
            hold_cnt        <= '0;
            retry_cnt       <= '0;
            lock_loss_cnt   <= '0;
            pll_powerdown_n <= 1'b0;
            fabric_reset    <= 1'b1;
            locked          <= 1'b0;
            fail            <= 1'b0;
        end else begin
            state           <= state_nxt;
            pd_cnt          <= pd_nxt;
            filt_cnt        <= filt_nxt;
            tmo_cnt         <= tmo_nxt;
            hold_cnt        <= hold_nxt;
            retry_cnt       <= retry_nxt;
            lock_loss_cnt   <= loss_nxt;
            pll_powerdown_n <= (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_HOLD) ||
                               (state_nxt == ST_RUN);
            fabric_reset    <= (state_nxt != ST_RUN);
            locked          <= (state_nxt == ST_RUN);
            fail            <= (state_nxt == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed testbench for pll_lock_supervisor with hand-computed edge timings.
module tb_pll_lock_supervisor;
    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_powerdown_n;
    logic       fabric_reset;
    logic       locked;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    pll_lock_supervisor #(
        .PD_CYCLES   (8),
        .LOCK_FILTER (4),
        .LOCK_TIMEOUT(100),
        .RST_HOLD    (4),
        .RETRY_MAX   (2)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .pll_lock       (pll_lock),
        .relock_req     (relock_req),
        .pll_powerdown_n(pll_powerdown_n),
        .fabric_reset   (fabric_reset),
        .locked         (locked),
        .fail           (fail),
        .retry_cnt      (retry_cnt),
        .lock_loss_cnt  (lock_loss_cnt)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; pll_lock = 1'b0; relock_req = 1'b0;
        tick(); tick();
        chk_cnt++; if (pll_powerdown_n !== 1'b0) $display("FAIL reset_pd_n got %b want 0", pll_powerdown_n); else pass_cnt++;
        chk_cnt++; if (fabric_reset !== 1'b1) $display("FAIL reset_fabric_reset got %b want 1", fabric_reset); else pass_cnt++;
        chk_cnt++; if (locked !== 1'b0) $display("FAIL reset_locked got %b want 0", locked); else pass_cnt++;
        chk_cnt++; if (fail !== 1'b0) $display("FAIL reset_fail got %b want 0", fail); else pass_cnt++;
        chk_cnt++; if (retry_cnt !== 4'd0) $display("FAIL reset_retry got %0d want 0", retry_cnt); else pass_cnt++;
        chk_cnt++; if (lock_loss_cnt !== 8'd0) $display("FAIL reset_loss got %0d want 0", lock_loss_cnt); else pass_cnt++;
    endtask

    task automatic test_normal_lock();
        int pd_rise = 0;
        int rel = 0;
        int lk = 0;
        Reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (pll_powerdown_n === 1'b1 && pd_rise == 0) pd_rise = k;
            if (fabric_reset === 1'b0 && rel == 0) rel = k;
            if (locked === 1'b1 && lk == 0) lk = k;
            if (k == 20) pll_lock = 1'b1;
        end
        chk_cnt++; if (pd_rise != 8) $display("FAIL normal_pd_rise_edge got %0d want 8", pd_rise); else pass_cnt++;
        chk_cnt++; if (rel != 30) $display("FAIL normal_release_edge got %0d want 30", rel); else pass_cnt++;
        chk_cnt++; if (lk != 30) $display("FAIL normal_locked_edge got %0d want 30", lk); else pass_cnt++;
        chk_cnt++; if (retry_cnt !== 4'd0) $display("FAIL normal_retry got %0d want 0", retry_cnt); else pass_cnt++;
        chk_cnt++; if (fail !== 1'b0) $display("FAIL normal_fail got %b want 0", fail); else pass_cnt++;
    endtask

    task automatic test_lock_loss();
        pll_lock = 1'b0;
        tick(); tick();
        chk_cnt++; if (locked !== 1'b1) $display("FAIL loss_locked_edge2 got %b want 1", locked); else pass_cnt++;
        tick();
        chk_cnt++; if (locked !== 1'b0) $display("FAIL loss_locked_edge3 got %b want 0", locked); else pass_cnt++;
        chk_cnt++; if (fabric_reset !== 1'b1) $display("FAIL loss_fabric_reset got %b want 1", fabric_reset); else pass_cnt++;
        chk_cnt++; if (pll_powerdown_n !== 1'b0) $display("FAIL loss_pd_n got %b want 0", pll_powerdown_n); else pass_cnt++;
        chk_cnt++; if (lock_loss_cnt !== 8'd1) $display("FAIL loss_count got %0d want 1", lock_loss_cnt); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int got_run = 0;
        pll_lock = 1'b1;
        for (int k = 0; k < 60 && got_run == 0; k++) begin
            tick();
            if (locked === 1'b1) got_run = 1;
        end
        chk_cnt++; if (got_run != 1) $display("FAIL simul_reach_run got %0d want 1", got_run); else pass_cnt++;
        pll_lock = 1'b0;
        tick(); tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk_cnt++; if (locked !== 1'b0) $display("FAIL simul_locked got %b want 0", locked); else pass_cnt++;
        chk_cnt++; if (pll_powerdown_n !== 1'b0) $display("FAIL simul_pd_n got %b want 0", pll_powerdown_n); else pass_cnt++;
        chk_cnt++; if (lock_loss_cnt !== 8'd1) $display("FAIL simul_loss_unchanged got %0d want 1", lock_loss_cnt); else pass_cnt++;
    endtask

    task automatic test_relock_powerdown();
        int pd_rise = 0;
        int early = 0;
        tick(); tick(); tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        for (int k = 5; k <= 20; k++) begin
            tick();
            if (pll_powerdown_n === 1'b1 && pd_rise == 0) pd_rise = k;
        end
        if (pd_rise != 0 && pd_rise < 12) early = 1;
        chk_cnt++; if (pd_rise != 12) $display("FAIL pd_restart_rise_edge got %0d want 12", pd_rise); else pass_cnt++;
        chk_cnt++; if (early != 0) $display("FAIL pd_restart_early got %0d want 0", early); else pass_cnt++;
    endtask

    task automatic test_loss_saturation();
        int expected = 1;
        int stuck = 0;
        int mid_val = -1;
        for (int i = 0; i < 300 && stuck == 0; i++) begin
            int got_run = 0;
            pll_lock = 1'b1;
            for (int k = 0; k < 60 && got_run == 0; k++) begin
                tick();
                if (locked === 1'b1) got_run = 1;
            end
            if (got_run == 0) stuck = 1;
            pll_lock = 1'b0;
            tick(); tick(); tick();
            expected = (expected < 255) ? expected + 1 : 255;
            if (i == 99) mid_val = int'(lock_loss_cnt);
        end
        chk_cnt++; if (stuck != 0) $display("FAIL sat_relock_timeout got %0d want 0", stuck); else pass_cnt++;
        chk_cnt++; if (mid_val != 101) $display("FAIL sat_count_mid got %0d want 101", mid_val); else pass_cnt++;
        chk_cnt++; if (int'(lock_loss_cnt) != expected) $display("FAIL sat_count_model got %0d want %0d", lock_loss_cnt, expected); else pass_cnt++;
        chk_cnt++; if (lock_loss_cnt !== 8'd255) $display("FAIL sat_count got %0d want 255", lock_loss_cnt); else pass_cnt++;
    endtask

    task automatic test_glitchy_lock();
        int found = 0;
        int rel = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            tick();
            if (pll_powerdown_n === 1'b1) found = 1;
        end
        chk_cnt++; if (found != 1) $display("FAIL glitch_reach_wait got %0d want 1", found); else pass_cnt++;
        pll_lock = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 3) pll_lock = 1'b0;
            if (k == 4) pll_lock = 1'b1;
            if (fabric_reset === 1'b0 && rel == 0) rel = k;
        end
        chk_cnt++; if (rel != 14) $display("FAIL glitch_release_edge got %0d want 14", rel); else pass_cnt++;
        chk_cnt++; if (locked !== 1'b1) $display("FAIL glitch_locked got %b want 1", locked); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int found = 0;
        int pd_rise = 0;
        pll_lock = 1'b0;
        tick(); tick(); tick();
        pll_lock = 1'b1;
        for (int k = 0; k < 20 && found == 0; k++) begin
            tick();
            if (pll_powerdown_n === 1'b1) found = 1;
        end
        chk_cnt++; if (found != 1) $display("FAIL areset_reach_wait got %0d want 1", found); else pass_cnt++;
        tick(); tick(); tick(); tick(); tick();
        chk_cnt++; if (pll_powerdown_n !== 1'b1) $display("FAIL areset_hold_pd_n got %b want 1", pll_powerdown_n); else pass_cnt++;
        chk_cnt++; if (fabric_reset !== 1'b1) $display("FAIL areset_hold_fabric_reset got %b want 1", fabric_reset); else pass_cnt++;
        #3;
        Reset = 1'b1;
        #1;
        chk_cnt++; if (pll_powerdown_n !== 1'b0) $display("FAIL areset_pd_n got %b want 0", pll_powerdown_n); else pass_cnt++;
        chk_cnt++; if (fabric_reset !== 1'b1) $display("FAIL areset_fabric_reset got %b want 1", fabric_reset); else pass_cnt++;
        chk_cnt++; if (locked !== 1'b0) $display("FAIL areset_locked got %b want 0", locked); else pass_cnt++;
        chk_cnt++; if (fail !== 1'b0) $display("FAIL areset_fail got %b want 0", fail); else pass_cnt++;
        chk_cnt++; if (retry_cnt !== 4'd0) $display("FAIL areset_retry got %0d want 0", retry_cnt); else pass_cnt++;
        chk_cnt++; if (lock_loss_cnt !== 8'd0) $display("FAIL areset_loss got %0d want 0", lock_loss_cnt); else pass_cnt++;
        tick();
        Reset = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (pll_powerdown_n === 1'b1 && pd_rise == 0) pd_rise = k;
        end
        chk_cnt++; if (pd_rise != 8) $display("FAIL areset_restart_edge got %0d want 8", pd_rise); else pass_cnt++;
    endtask

    task automatic test_timeout_fail();
        int held_bad = 0;
        int pd_rise = 0;
        Reset = 1'b1; pll_lock = 1'b0; relock_req = 1'b0;
        tick();
        Reset = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (k == 8) begin
                chk_cnt++; if (pll_powerdown_n !== 1'b1) $display("FAIL tmo_pd_n_e8 got %b want 1", pll_powerdown_n); else pass_cnt++;
            end
            if (k == 107) begin
                chk_cnt++; if (retry_cnt !== 4'd0) $display("FAIL tmo_retry_e107 got %0d want 0", retry_cnt); else pass_cnt++;
                chk_cnt++; if (pll_powerdown_n !== 1'b1) $display("FAIL tmo_pd_n_e107 got %b want 1", pll_powerdown_n); else pass_cnt++;
            end
            if (k == 108) begin
                chk_cnt++; if (retry_cnt !== 4'd1) $display("FAIL tmo_retry_e108 got %0d want 1", retry_cnt); else pass_cnt++;
                chk_cnt++; if (pll_powerdown_n !== 1'b0) $display("FAIL tmo_pd_n_e108 got %b want 0", pll_powerdown_n); else pass_cnt++;
                chk_cnt++; if (fail !== 1'b0) $display("FAIL tmo_fail_e108 got %b want 0", fail); else pass_cnt++;
            end
            if (k == 116) begin
                chk_cnt++; if (pll_powerdown_n !== 1'b1) $display("FAIL tmo_pd_n_e116 got %b want 1", pll_powerdown_n); else pass_cnt++;
            end
            if (k == 215) begin
                chk_cnt++; if (fail !== 1'b0) $display("FAIL tmo_fail_e215 got %b want 0", fail); else pass_cnt++;
            end
            if (k == 216) begin
                chk_cnt++; if (fail !== 1'b1) $display("FAIL tmo_fail_e216 got %b want 1", fail); else pass_cnt++;
                chk_cnt++; if (retry_cnt !== 4'd2) $display("FAIL tmo_retry_e216 got %0d want 2", retry_cnt); else pass_cnt++;
                chk_cnt++; if (pll_powerdown_n !== 1'b0) $display("FAIL tmo_pd_n_e216 got %b want 0", pll_powerdown_n); else pass_cnt++;
            end
            if (k > 216 && (pll_powerdown_n !== 1'b0 || fail !== 1'b1)) held_bad = 1;
        end
        chk_cnt++; if (held_bad != 0) $display("FAIL tmo_fail_held got %0d want 0", held_bad); else pass_cnt++;
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk_cnt++; if (fail !== 1'b0) $display("FAIL relock_fail got %b want 0", fail); else pass_cnt++;
        chk_cnt++; if (retry_cnt !== 4'd0) $display("FAIL relock_retry got %0d want 0", retry_cnt); else pass_cnt++;
        chk_cnt++; if (pll_powerdown_n !== 1'b0) $display("FAIL relock_pd_n got %b want 0", pll_powerdown_n); else pass_cnt++;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (pll_powerdown_n === 1'b1 && pd_rise == 0) pd_rise = k;
        end
        chk_cnt++; if (pd_rise != 8) $display("FAIL relock_pd_rise_edge got %0d want 8", pd_rise); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_normal_lock();
        test_lock_loss();
        test_simultaneous();
        test_relock_powerdown();
        test_loss_saturation();
        test_glitchy_lock();
        test_async_reset();
        test_timeout_fail();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequencing and supervision stage for the fabric PLL/CCC clock generator. It runs on a free-running clock that does not depend on the PLL and drives the PLL power-down input. It watches the PLL lock output and releases a fabric-domain reset only after lock has been stable for a programmed time. On lock loss or lock timeout it power-cycles the PLL, with bounded retries, and reports status to the control/register layer.

## Interface
Parameters:
- PD_CYCLES, 64: cycles `pll_powerdown_n` is held low per power-cycle; ≥2.
- LOCK_FILTER, 16: consecutive synchronized-high lock cycles required to accept lock; ≥1.
- LOCK_TIMEOUT, 50000: cycles allowed in WAIT_LOCK before a retry; ≥2.
- RST_HOLD, 32: cycles `fabric_reset` stays asserted after lock is accepted; ≥1.
- RETRY_MAX, 3: consecutive timeouts before FAIL; 1..15.

Ports:
- `Clock`, in, 1: free-running supervisor clock (not the PLL output).
- `Reset`, in, 1: asynchronous, active-high reset.
- `pll_lock`, in, 1: PLL lock, asynchronous to `Clock`.
- `relock_req`, in, 1: single-cycle request to force a full power-cycle.
- `pll_powerdown_n`, out, 1: to PLL POWERDOWN_N; 0 = PLL powered down.
- `fabric_reset`, out, 1: active-high reset for logic clocked by the PLL output.
- `locked`, out, 1: 1 only in RUN.
- `fail`, out, 1: 1 only in FAIL.
- `retry_cnt`, out, 4: consecutive lock timeouts since the last successful lock or `relock_req`.
- `lock_loss_cnt`, out, 8: lock losses seen in RUN; saturates at 255.

## Operation
- `pll_lock` passes through a 2-flop synchronizer to produce `lock_s`. Reset value is 0.
- All outputs are registered. Reset values: `pll_powerdown_n` 0, `fabric_reset` 1, `locked` 0, `fail` 0, `retry_cnt` 0, `lock_loss_cnt` 0, state POWERDOWN, all counters 0.
- **POWERDOWN**:
  - `pll_powerdown_n` = 0, `fabric_reset` = 1.
  - After PD_CYCLES cycles in this state, go to WAIT_LOCK.
- **WAIT_LOCK**:
  - `pll_powerdown_n` = 1, `fabric_reset` = 1.
  - The filter counter increments while `lock_s` = 1 and clears to 0 when `lock_s` = 0.
  - When the filter counter reaches LOCK_FILTER, go to HOLD.
  - The timeout counter increments every cycle. When it reaches LOCK_TIMEOUT, increment `retry_cnt`.
  - On timeout: if the new `retry_cnt` equals RETRY_MAX, go to FAIL; otherwise go to POWERDOWN.
  - If filter completion and timeout occur in the same cycle, filter completion wins.
- **HOLD**:
  - `fabric_reset` = 1.
  - `lock_s` = 0 returns to WAIT_LOCK with both filter and timeout counters cleared; this is not counted as a lock loss.
  - After RST_HOLD cycles with lock held, go to RUN and clear `retry_cnt`.
- **RUN**:
  - `fabric_reset` = 0, `locked` = 1.
  - `lock_s` = 0 increments `lock_loss_cnt` (saturating) and goes to POWERDOWN.
- **FAIL**:
  - `pll_powerdown_n` = 0, `fabric_reset` = 1, `fail` = 1.
  - Exits only on `relock_req` or `Reset`.
- **`relock_req`**:
  - In any state other than POWERDOWN, it forces POWERDOWN, clears `retry_cnt`, and clears `fail`.
  - In POWERDOWN it restarts the PD_CYCLES count.
  - It has priority over every other transition. A simultaneous lock loss in RUN is not counted.
- All counters are cleared on state entry. Counter widths are sized by `$clog2` of their parameter + 1, with no wrap.

## Timing
- Synchronizer latency: 2 cycles from a `pll_lock` edge to `lock_s`.
- Output updates: outputs change on the same edge as the state register. `pll_powerdown_n` rises on the edge entering WAIT_LOCK, PD_CYCLES cycles after entering POWERDOWN.
- Best-case release: `fabric_reset` falls `2 + LOCK_FILTER + RST_HOLD` cycles after `pll_lock` rises, measured while in WAIT_LOCK.
- Lock loss in RUN: `locked` falls and `fabric_reset` rises 3 edges after `pll_lock` falls (2 synchronizer edges + 1 state edge). `pll_powerdown_n` falls on that same edge.
- `Reset` mid-operation: all outputs return to their reset values immediately (asynchronous assert). Operation restarts from POWERDOWN on the first clock after release.
- `relock_req` is sampled every cycle. Its effect appears on the next edge.

## Test plan
Bench parameters: PD_CYCLES=8, LOCK_FILTER=4, LOCK_TIMEOUT=100, RST_HOLD=4, RETRY_MAX=2.
- **Normal lock.** Release reset; `pll_lock` = 1 from cycle 20. Required: `pll_powerdown_n` rises at cycle 8; `fabric_reset` falls and `locked` rises at cycle 30; `retry_cnt` = 0.
- **Glitchy lock.** In WAIT_LOCK, drive `pll_lock` high 3 cycles, low 1, then high. Required: the filter restarts, and HOLD is entered only after 4 consecutive `lock_s` = 1 cycles.
- **Timeout and fail.** Hold `pll_lock` = 0. Required: `retry_cnt` becomes 1 after the first 100-cycle WAIT_LOCK, a second power-cycle follows, then `retry_cnt` = 2, `fail` = 1, and `pll_powerdown_n` = 0 held indefinitely. Then pulse `relock_req`. Required: `fail` = 0 and `retry_cnt` = 0 on the next edge.
- **Lock loss.** In RUN, drop `pll_lock`. Required: 3 edges later `locked` = 0, `fabric_reset` = 1, `pll_powerdown_n` = 0, `lock_loss_cnt` = 1. Repeat 300 times and require `lock_loss_cnt` = 255.
- **Simultaneous and asynchronous events.** Pulse `relock_req` on the cycle lock loss reaches RUN. Required: POWERDOWN is entered and `lock_loss_cnt` is unchanged. Assert `Reset` mid-HOLD. Required: outputs take their reset values before the next `Clock` edge.
